// File: rtl/lc3b_types.sv
// Shared gshare types: history checkpoints, controller states and
// 2-bit PHT counter encodings with their saturating update.
package lc3b_types;

  localparam int BHT_HMAX = 15;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Fields sized for the widest legal history; users take low bits.
  typedef struct packed {
    logic [BHT_HMAX-1:0] idx;
    logic [BHT_HMAX-1:0] ghr;
    logic [1:0]          ctr;
    logic                pred;
  } bht_ckpt_t;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    RECOVER
  } bht_ctrl_state_t;

  function automatic logic [1:0] ctr_update(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] r;
    r = c;
    unique case (1'b1)
      taken && (c != ST):   r = c + 2'd1;
      !taken && (c != SNT): r = c - 2'd1;
      default:              r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bht_ckpt_fifo.sv
// In-order checkpoint queue for outstanding predictions.
// Flush empties the queue and overrides push/pop in that cycle.
import lc3b_types::*;

module bht_ckpt_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  bht_ckpt_t     din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output bht_ckpt_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  bht_ckpt_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = inc(wr_q);
      if (do_pop)  rd_d = inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/global_bht_update_ctrl.sv
// Gshare sequencer: forms PHT index, speculates history, retires
// checkpoints in order, writes back counters and repairs on mispredict.
import lc3b_types::*;

module global_bht_update_ctrl #(
  parameter  int HIST_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [15:0]       pred_pc,
  output logic [HIST_W-1:0] pred_idx,
  input  logic [1:0]        pht_rdata,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              mispredict,
  output logic              pht_we,
  output logic [HIST_W-1:0] pht_widx,
  output logic [1:0]        pht_wdata,
  output logic              ghr_write,
  output logic [HIST_W-1:0] ghr_datain,
  input  logic [HIST_W-1:0] ghr_dataout,
  output logic [CW-1:0]     occupancy,
  output logic              err_underflow
);

  bht_ctrl_state_t   state_q, state_d;
  bht_ckpt_t         head;
  bht_ckpt_t         ckpt;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [1:0]        ctr_eff;
  logic              pred_fire;
  logic              resolve;
  logic              push;

  logic              pht_we_q, pht_we_d;
  logic [HIST_W-1:0] pht_widx_q, pht_widx_d;
  logic [1:0]        pht_wdata_q, pht_wdata_d;
  logic              err_q, err_d;

  assign pred_idx = ghr_dataout ^ pred_pc[HIST_W:1];

  // Last cycle's writeback may target the index being read now.
  assign ctr_eff = (pht_we_q && pht_widx_q == pred_idx)
                 ? pht_wdata_q : pht_rdata;

  assign pred_taken = ctr_eff[1];
  assign pred_ready = (state_q == RUN) && !full;
  assign pred_fire  = pred_valid && pred_ready;
  assign resolve    = res_valid && !empty;
  assign mispredict = resolve && (res_taken != head.pred);
  assign push       = pred_fire && !mispredict;

  always_comb begin
    ckpt      = '0;
    ckpt.idx  = BHT_HMAX'(pred_idx);
    ckpt.ghr  = BHT_HMAX'(ghr_dataout);
    ckpt.ctr  = ctr_eff;
    ckpt.pred = ctr_eff[1];
  end

  bht_ckpt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (ckpt),
    .pop_i   (resolve),
    .flush_i (mispredict),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (mispredict) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // History repair takes priority over speculative update.
  always_comb begin
    ghr_write  = 1'b0;
    ghr_datain = '0;
    unique case (state_q)
      INIT: ghr_write = rst_n;
      default: begin
        if (mispredict) begin
          ghr_write  = 1'b1;
          ghr_datain = {head.ghr[HIST_W-2:0], res_taken};
        end else if (pred_fire) begin
          ghr_write  = 1'b1;
          ghr_datain = {ghr_dataout[HIST_W-2:0], pred_taken};
        end
      end
    endcase
  end

  always_comb begin
    pht_we_d    = resolve;
    pht_widx_d  = pht_widx_q;
    pht_wdata_d = pht_wdata_q;
    if (resolve) begin
      pht_widx_d  = head.idx[HIST_W-1:0];
      pht_wdata_d = ctr_update(head.ctr, res_taken);
    end
    err_d = err_q || (res_valid && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pht_we_q    <= 1'b0;
      pht_widx_q  <= '0;
      pht_wdata_q <= SNT;
      err_q       <= 1'b0;
    end else begin
      pht_we_q    <= pht_we_d;
      pht_widx_q  <= pht_widx_d;
      pht_wdata_q <= pht_wdata_d;
      err_q       <= err_d;
    end
  end

  assign pht_we        = pht_we_q;
  assign pht_widx      = pht_widx_q;
  assign pht_wdata     = pht_wdata_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_global_bht_update_ctrl.sv
// Randomized bench: abstract gshare model plus a writeback scoreboard.
// PHT array and history register are modelled as plain storage.
module tb_global_bht_update_ctrl;

  localparam int HW = 8;
  localparam int D  = 4;

  logic          clk;
  logic          rst_n;
  logic          pred_valid;
  logic          pred_ready;
  logic [15:0]   pred_pc;
  logic [HW-1:0] pred_idx;
  logic [1:0]    pht_rdata;
  logic          pred_taken;
  logic          res_valid;
  logic          res_taken;
  logic          mispredict;
  logic          pht_we;
  logic [HW-1:0] pht_widx;
  logic [1:0]    pht_wdata;
  logic          ghr_write;
  logic [HW-1:0] ghr_datain;
  logic [HW-1:0] ghr_dataout = 8'h5A;
  logic [2:0]    occupancy;
  logic          err_underflow;

  global_bht_update_ctrl #(
    .HIST_W(HW),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pred_valid   (pred_valid),
    .pred_ready   (pred_ready),
    .pred_pc      (pred_pc),
    .pred_idx     (pred_idx),
    .pht_rdata    (pht_rdata),
    .pred_taken   (pred_taken),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .mispredict   (mispredict),
    .pht_we       (pht_we),
    .pht_widx     (pht_widx),
    .pht_wdata    (pht_wdata),
    .ghr_write    (ghr_write),
    .ghr_datain   (ghr_datain),
    .ghr_dataout  (ghr_dataout),
    .occupancy    (occupancy),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] pht_mem [256];

  always_comb pht_rdata = pht_mem[pred_idx];

  always @(posedge clk) begin
    if (pht_we) pht_mem[pht_widx] <= pht_wdata;
    if (ghr_write) ghr_dataout <= ghr_datain;
  end

  typedef struct {
    int idx;
    int ghr;
    int ctr;
    int pred;
  } ent_t;

  typedef struct {
    int idx;
    int data;
  } wb_t;

  ent_t mq[$];
  wb_t  wbq[$];
  int   m_st;
  int   m_ghr;
  int   m_err;
  int   pend_we;
  int   pend_idx;
  int   pend_data;
  int   checks;
  int   fails;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int t);
    if (t != 0) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  // Writebacks are due one edge after their resolve.
  always @(posedge clk) begin
    wb_t e;
    int  exp_we;
    #1;
    if (rst_n) begin
      exp_we = (wbq.size() > 0) ? 1 : 0;
      chk("pht_we", pht_we, exp_we);
      if (exp_we != 0) begin
        e = wbq.pop_front();
        if (pht_we) begin
          chk("pht_widx", pht_widx, e.idx);
          chk("pht_wdata", pht_wdata, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    #1;
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_pht_we", pht_we, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_ghr_write", ghr_write, 0);
    repeat (2) @(negedge clk);
    mq.delete();
    wbq.delete();
    m_st    = 0;
    m_ghr   = int'(ghr_dataout);
    m_err   = 0;
    pend_we = 0;
    rst_n   = 1'b1;
  endtask

  task automatic cycle(input bit free_res);
    int idx, ctr, rdy, fire, rsv, mis, w, d, g0;
    logic [15:0] pc;
    pred_valid = ($urandom_range(0, 9) < 7);
    pc = 16'($urandom);
    if (pend_we != 0 && $urandom_range(0, 2) == 0)
      pc[8:1] = 8'(m_ghr ^ pend_idx);
    pred_pc = pc;
    if (free_res)
      res_valid = ($urandom_range(0, 3) == 0);
    else
      res_valid = (mq.size() > 0) && ($urandom_range(0, 9) < 3);
    res_taken = 1'($urandom_range(0, 1));
    #1;
    rdy  = (m_st == 1 && mq.size() < D) ? 1 : 0;
    idx  = (m_ghr ^ int'(pc[8:1])) & 255;
    ctr  = (pend_we != 0 && pend_idx == idx)
         ? pend_data : int'(pht_mem[idx]);
    fire = (pred_valid && rdy != 0) ? 1 : 0;
    rsv  = (res_valid && mq.size() > 0) ? 1 : 0;
    mis  = (rsv != 0 && int'(res_taken) != mq[0].pred) ? 1 : 0;
    chk("pred_ready", pred_ready, rdy);
    chk("pred_idx", pred_idx, idx);
    chk("occupancy", occupancy, mq.size());
    chk("mispredict", mispredict, mis);
    chk("err_underflow", err_underflow, m_err);
    if (fire != 0) chk("pred_taken", pred_taken, ctr / 2);
    w = 1;
    if (m_st == 0)
      d = 0;
    else if (mis != 0)
      d = ((mq[0].ghr * 2) + int'(res_taken)) & 255;
    else if (fire != 0)
      d = ((m_ghr * 2) + ctr / 2) & 255;
    else begin
      w = 0;
      d = 0;
    end
    chk("ghr_write", ghr_write, w);
    if (w != 0) chk("ghr_datain", ghr_datain, d);
    if (res_valid && mq.size() == 0) m_err = 1;
    pend_we = rsv;
    if (rsv != 0) begin
      pend_idx  = mq[0].idx;
      pend_data = sat(mq[0].ctr, int'(res_taken));
      wbq.push_back('{pend_idx, pend_data});
    end
    g0 = m_ghr;
    if (w != 0) m_ghr = d;
    if (mis != 0) mq.delete();
    else begin
      if (rsv != 0) void'(mq.pop_front());
      if (fire != 0) mq.push_back('{idx, g0, ctr, ctr / 2});
    end
    if (m_st == 0)      m_st = 1;
    else if (mis != 0)  m_st = 2;
    else if (m_st == 2) m_st = 1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    pred_pc = '0;
    foreach (pht_mem[i]) pht_mem[i] = 2'($urandom_range(0, 3));
    do_reset();
    repeat (1500) cycle(1'b0);
    repeat (300) cycle(1'b1);
    @(negedge clk);
    do_reset();
    repeat (600) cycle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/global_bht_update_ctrl.md
Name: global_bht_update_ctrl

Overview:
Controller that sequences the global branch history register and the pattern history table (PHT) of the LC-3b gshare predictor. It forms the PHT index for each fetch-stage prediction and speculatively shifts the predicted outcome into the history. It keeps an in-order checkpoint queue of outstanding predictions, retires them on resolution from execute, and writes back the 2-bit PHT counters. On a mispredict it restores the history and flushes the queue. It sits between fetch, execute, the history register (write/datain/dataout) and the PHT array.

Parameters:
HIST_W, 8, history width and PHT index width (legal range 2..15)
DEPTH, 4, number of outstanding-prediction checkpoints (power of 2)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
pred_valid  in  1  fetch requests a prediction
pred_ready  out  1  controller can accept a prediction
pred_pc  in  16  PC of the branch
pred_idx  out  HIST_W  PHT read index = ghr_dataout ^ pred_pc[HIST_W:1], combinational
pht_rdata  in  2  PHT counter at pred_idx, same cycle
pred_taken  out  1  prediction = effective counter bit 1
res_valid  in  1  execute resolves the oldest outstanding branch
res_taken  in  1  actual outcome
mispredict  out  1  combinational pulse: resolved outcome differs from its prediction
pht_we  out  1  PHT write enable, registered
pht_widx  out  HIST_W  PHT write index
pht_wdata  out  2  updated counter
ghr_write  out  1  history register write enable
ghr_datain  out  HIST_W  history register write data
ghr_dataout  in  HIST_W  current history register value
occupancy  out  $clog2(DEPTH)+1  outstanding checkpoints
err_underflow  out  1  sticky: res_valid seen with empty queue

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=INIT, queue empty, occupancy=0.
  - pred_ready=0, pht_we=0, err_underflow=0.
  - ghr_write=0 while rst_n is low.
- FSM states: INIT, RUN, RECOVER.
  - INIT: lasts one cycle after reset release. Drives ghr_write=1, ghr_datain=0, pred_ready=0. Then goes to RUN.
  - RUN: normal operation.
  - RECOVER: entered on a mispredict. Lasts one cycle with pred_ready=0, then goes to RUN.
- pred_ready = (state==RUN) && (occupancy<DEPTH). There is no same-cycle pop bypass.
- Effective counter (ctr_eff):
  - Equals pht_wdata when pht_we && pht_widx==pred_idx (forwarding).
  - Otherwise equals pht_rdata.
- Predict fire (pred_valid && pred_ready):
  - Push checkpoint {idx=pred_idx, ghr=ghr_dataout, ctr=ctr_eff, pred=ctr_eff[1]}.
  - Drive ghr_write=1, ghr_datain={ghr_dataout[HIST_W-2:0], pred_taken}.
- Resolve (res_valid && occupancy>0):
  - Pop the head checkpoint.
  - Next cycle: pht_we=1, pht_widx=head.idx, pht_wdata = saturating counter of head.ctr (increment if res_taken, else decrement; 11 stays 11, 00 stays 00).
- Mispredict (resolve && res_taken!=head.pred):
  - mispredict=1 in the same cycle.
  - Drive ghr_write=1, ghr_datain={head.ghr[HIST_W-2:0], res_taken}. This overrides any concurrent predict write.
  - Flush all entries (occupancy=0 next cycle). A predict firing in the same cycle is squashed: not pushed. Fetch discards it on seeing mispredict.
  - state → RECOVER.
- Correct resolve with concurrent predict fire: both complete, occupancy unchanged, ghr write comes from the predict.
- res_valid with empty queue: ignored (no pop, no pht_we), err_underflow set until reset.
- Queue pointers wrap modulo DEPTH. Occupancy saturates at DEPTH by construction.
- Reset mid-operation discards all checkpoints and any pending pht_we.

Decomposition:
- lc3b_types additions:
  - typedef bht_ckpt_t struct {idx, ghr, ctr, pred}.
  - typedef bht_ctrl_state_t enum {INIT, RUN, RECOVER}.
  - constants for the 2-bit counter values SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, bht_ckpt_fifo: a DEPTH-entry FIFO of bht_ckpt_t with push, pop, flush, head, count, and asynchronous active-low reset.

Test Plan:
1. Release rst_n → one cycle with ghr_write=1, ghr_datain=0x00, pred_ready=0; next cycle pred_ready=1, occupancy=0.
2. ghr_dataout=0x00, pred_pc=0x0010, pht_rdata=10, predict fire → pred_idx=0x08, pred_taken=1, ghr_datain=0x01, occupancy=1.
3. Four predicts without a resolve → occupancy=4, pred_ready=0. One correct resolve → pred_ready=1 next cycle. Head ctr=10 taken → pht_we=1, pht_wdata=11 one cycle later.
4. Head {ghr=0x05, ctr=10, pred=1}, res_taken=0, concurrent predict fire → mispredict=1, ghr_datain=0x0A, predict squashed, occupancy=0, one RECOVER cycle with pred_ready=0, then pht_wdata=01.
5. Saturation: ctr=11 resolved taken → pht_wdata=11; ctr=00 resolved not-taken → pht_wdata=00. Forwarding: pht_we to idx 0x08 with wdata=11 while predicting idx 0x08 with pht_rdata=01 → pred_taken=1.
6. res_valid=1 with occupancy=0 → no pht_we, err_underflow=1 and held until rst_n=0.
